// File: rtl/dmem_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | dmem_arbiter_pkg                                                     |
// | Shared types for the data-memory path: access sizes, arbiter states. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package dmem_arbiter_pkg;

    // Encodings match the core's func3 field for loads and stores.
    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RESP_CORE = 2'd1,
        ST_RESP_DBG  = 2'd2
    } arb_state_t;

    typedef enum logic [0:0] {
        GNT_CORE = 1'b0,
        GNT_DBG  = 1'b1
    } grant_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ops_t;

    localparam logic [3:0] c_MASK_ALL = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_lsu_align.sv
// +----------------------------------------------------------------------+
// | lsu_align                                                            |
// | Store lane steering / byte mask, load extension, misalign detection. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_align
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [2:0]  st_size,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_wdata_lane,
    output logic [3:0]  st_mask,
    output logic        misalign,
    input  logic [1:0]  ld_off,
    input  logic [2:0]  ld_size,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        st_wdata_lane = '0;
        st_mask       = '0;
        misalign      = 1'b0;
        case (st_size)
            SZ_B, SZ_BU: begin
                st_wdata_lane = {4{st_wdata[7:0]}};
                st_mask       = 4'b0001 << st_off;
            end
            SZ_H, SZ_HU: begin
                st_wdata_lane = {2{st_wdata[15:0]}};
                st_mask       = 4'b0011 << {st_off[1], 1'b0};
                misalign      = st_off[0];
            end
            SZ_W: begin
                st_wdata_lane = st_wdata;
                st_mask       = c_MASK_ALL;
                misalign      = |st_off;
            end
            default: misalign = 1'b1;
        endcase
    end

    always_comb begin
        w_byte = ld_raw[7:0];
        case (ld_off)
            2'd0:    w_byte = ld_raw[7:0];
            2'd1:    w_byte = ld_raw[15:8];
            2'd2:    w_byte = ld_raw[23:16];
            default: w_byte = ld_raw[31:24];
        endcase
        w_half = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    end

    always_comb begin
        ld_data = ld_raw;
        case (ld_size)
            SZ_B:    ld_data = {{24{w_byte[7]}}, w_byte};
            SZ_BU:   ld_data = {24'd0, w_byte};
            SZ_H:    ld_data = {{16{w_half[15]}}, w_half};
            SZ_HU:   ld_data = {16'd0, w_half};
            default: ld_data = ld_raw;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// +----------------------------------------------------------------------+
// | dmem_arbiter                                                         |
// | Shares the single-port data memory between core load/store and debug.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int unsigned DBG_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    input  logic [2:0]        core_size,
    output logic              core_stall,
    output logic [31:0]       core_rdata,
    output logic              core_rvalid,
    output logic              core_misalign,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata
);

    arb_state_t r_state;
    grant_t     r_last_grant;
    logic [1:0] r_ld_off;
    logic [2:0] r_ld_size;

    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_mask;
    logic        w_misalign;
    logic [31:0] w_ld_data;
    logic        w_idle;
    logic        w_core_req;
    logic        w_core_ok;
    logic        w_dbg_ok;
    logic        w_dbg_wins;
    logic        w_gnt_core;
    logic        w_gnt_dbg;
    logic        w_unused_ok;

    assign w_unused_ok = ^dbg_addr[1:0];

    lsu_align u_lsu_align (
        .st_off        (core_addr[1:0]),
        .st_size       (core_size),
        .st_wdata      (core_wdata),
        .st_wdata_lane (w_st_wdata),
        .st_mask       (w_st_mask),
        .misalign      (w_misalign),
        .ld_off        (r_ld_off),
        .ld_size       (r_ld_size),
        .ld_raw        (mem_rdata),
        .ld_data       (w_ld_data)
    );

    assign w_idle     = (r_state == ST_IDLE) && !reset;
    assign w_core_req = (core_rd | core_wr) && !reset;
    assign w_core_ok  = w_core_req && !w_misalign && w_idle;
    assign w_dbg_ok   = dbg_req && w_idle;

    // On a tie the requester that did not win last time takes the slot.
    assign w_dbg_wins = (DBG_PRIO != 0) || (r_last_grant == GNT_CORE);
    assign w_gnt_core = w_core_ok && !(w_dbg_ok && w_dbg_wins);
    assign w_gnt_dbg  = w_dbg_ok && !(w_core_ok && !w_dbg_wins);

    always_comb begin
        mem_en    = w_gnt_core | w_gnt_dbg;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (w_gnt_core) begin
            mem_we   = core_wr;
            mem_addr = core_addr[ADDR_W-1:2];
            if (core_wr) begin
                mem_wdata = w_st_wdata;
                mem_wmask = w_st_mask;
            end
        end else if (w_gnt_dbg) begin
            mem_we   = dbg_we;
            mem_addr = dbg_addr[ADDR_W-1:2];
            if (dbg_we) begin
                mem_wdata = dbg_wdata;
                mem_wmask = c_MASK_ALL;
            end
        end
    end

    // In RESP_CORE the still-asserted request is the one being answered.
    assign core_misalign = w_core_req && w_misalign && (r_state != ST_RESP_CORE);
    assign core_stall    = w_core_req && !w_misalign && (r_state != ST_RESP_CORE)
                           && !(w_gnt_core && core_wr);
    assign dbg_gnt       = w_gnt_dbg;

    assign core_rvalid = (r_state == ST_RESP_CORE) && !reset;
    assign core_rdata  = core_rvalid ? w_ld_data : 32'd0;
    assign dbg_rvalid  = (r_state == ST_RESP_DBG) && !reset;
    assign dbg_rdata   = dbg_rvalid ? mem_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GNT_DBG;
            r_ld_off     <= 2'd0;
            r_ld_size    <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_core && !core_wr) begin
                        r_state <= ST_RESP_CORE;
                    end else if (w_gnt_dbg && !dbg_we) begin
                        r_state <= ST_RESP_DBG;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_gnt_core) begin
                r_last_grant <= GNT_CORE;
                r_ld_off     <= core_addr[1:0];
                r_ld_size    <= core_size;
            end
            if (w_gnt_dbg) begin
                r_last_grant <= GNT_DBG;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_dmem_arbiter                                                      |
// | Directed self-checking bench for dmem_arbiter (both priority modes). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_rd, core_wr;
    logic [31:0] core_addr, core_wdata;
    logic [2:0]  core_size;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic [31:0] mem_rdata;

    logic        core_stall, core_rvalid, core_misalign, dbg_gnt, dbg_rvalid, mem_en, mem_we;
    logic [31:0] core_rdata, dbg_rdata, mem_wdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wmask;

    logic        p_core_stall, p_core_rvalid, p_core_misalign, p_dbg_gnt, p_dbg_rvalid;
    logic        p_mem_en, p_mem_we;
    logic [31:0] p_core_rdata, p_dbg_rdata, p_mem_wdata;
    logic [29:0] p_mem_addr;
    logic [3:0]  p_mem_wmask;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DBG_PRIO(0)) u_dut_rr (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_size(core_size),
        .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .core_misalign(core_misalign),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DBG_PRIO(1)) u_dut_pr (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_size(core_size),
        .core_stall(p_core_stall), .core_rdata(p_core_rdata), .core_rvalid(p_core_rvalid),
        .core_misalign(p_core_misalign),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(p_dbg_gnt), .dbg_rdata(p_dbg_rdata), .dbg_rvalid(p_dbg_rvalid),
        .mem_en(p_mem_en), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
        .mem_wmask(p_mem_wmask), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic core_idle;
        core_rd = 1'b0;
        core_wr = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        core_rd = 1'b0; core_wr = 1'b0; core_addr = '0; core_wdata = '0; core_size = 3'b010;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; mem_rdata = '0;
        do_reset();
        #1;
        chk("rst_stall",  {31'd0, core_stall}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_rvalid", {31'd0, core_rvalid}, 32'd0);
        chk("rst_dbggnt", {31'd0, dbg_gnt}, 32'd0);
        tick();

        // SW 0x10
        core_wr = 1'b1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF; core_size = 3'b010;
        #1;
        chk("sw_en",    {31'd0, mem_en}, 32'd1);
        chk("sw_we",    {31'd0, mem_we}, 32'd1);
        chk("sw_addr",  {2'd0, mem_addr}, 32'h4);
        chk("sw_mask",  {28'd0, mem_wmask}, 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_stall", {31'd0, core_stall}, 32'd0);
        tick();

        // LB 0x13, then LBU 0x13
        core_wr = 1'b0; core_rd = 1'b1; core_addr = 32'h13; core_size = 3'b000;
        #1;
        chk("lb_stall_n", {31'd0, core_stall}, 32'd1);
        chk("lb_en",      {31'd0, mem_en}, 32'd1);
        chk("lb_we",      {31'd0, mem_we}, 32'd0);
        chk("lb_addr",    {2'd0, mem_addr}, 32'h4);
        tick();
        mem_rdata = 32'h80123456;
        #1;
        chk("lb_rvalid",  {31'd0, core_rvalid}, 32'd1);
        chk("lb_rdata",   core_rdata, 32'hFFFFFF80);
        chk("lb_stall_1", {31'd0, core_stall}, 32'd0);
        chk("lb_no_en",   {31'd0, mem_en}, 32'd0);
        tick();
        core_idle();
        #1;
        chk("gap_rvalid", {31'd0, core_rvalid}, 32'd0);
        chk("gap_rdata",  core_rdata, 32'd0);
        tick();
        core_rd = 1'b1; core_size = 3'b100;
        tick();
        #1;
        chk("lbu_rdata", core_rdata, 32'h00000080);
        tick();

        // LH at offset 2
        core_addr = 32'h6; core_size = 3'b001;
        tick();
        mem_rdata = 32'h9ABC0000;
        #1;
        chk("lh_rdata", core_rdata, 32'hFFFF9ABC);
        tick();

        // SH 0x12, SB 0x11
        core_rd = 1'b0; core_wr = 1'b1; core_addr = 32'h12; core_wdata = 32'h00001234;
        core_size = 3'b001;
        #1;
        chk("sh_mask",  {28'd0, mem_wmask}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'h12341234);
        tick();
        core_addr = 32'h11; core_wdata = 32'h000000A5; core_size = 3'b000;
        #1;
        chk("sb_mask",  {28'd0, mem_wmask}, 32'h2);
        chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        tick();

        // Misaligned LW and illegal size
        core_wr = 1'b0; core_rd = 1'b1; core_addr = 32'h6; core_size = 3'b010;
        #1;
        chk("mis_flag",  {31'd0, core_misalign}, 32'd1);
        chk("mis_en",    {31'd0, mem_en}, 32'd0);
        chk("mis_stall", {31'd0, core_stall}, 32'd0);
        tick();
        core_addr = 32'h8; core_size = 3'b011;
        #1;
        chk("ill_flag", {31'd0, core_misalign}, 32'd1);
        chk("ill_en",   {31'd0, mem_en}, 32'd0);
        tick();
        core_idle();

        // Round-robin conflict after reset: core first, then debug
        do_reset();
        core_rd = 1'b1; core_addr = 32'h20; core_size = 3'b010;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h43;
        #1;
        chk("rr1_core_addr", {2'd0, mem_addr}, 32'h8);
        chk("rr1_dbg_gnt",   {31'd0, dbg_gnt}, 32'd0);
        chk("rr1_stall",     {31'd0, core_stall}, 32'd1);
        tick();
        mem_rdata = 32'h11223344;
        #1;
        chk("rr2_rvalid",  {31'd0, core_rvalid}, 32'd1);
        chk("rr2_rdata",   core_rdata, 32'h11223344);
        chk("rr2_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
        chk("rr2_en",      {31'd0, mem_en}, 32'd0);
        tick();
        core_addr = 32'h24;
        #1;
        chk("rr3_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
        chk("rr3_addr",    {2'd0, mem_addr}, 32'h10);
        chk("rr3_we",      {31'd0, mem_we}, 32'd0);
        chk("rr3_stall",   {31'd0, core_stall}, 32'd1);
        tick();
        dbg_req = 1'b0;
        mem_rdata = 32'h55667788;
        #1;
        chk("rr4_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        chk("rr4_dbg_rdata",  dbg_rdata, 32'h55667788);
        chk("rr4_stall",      {31'd0, core_stall}, 32'd1);
        chk("rr4_core_rdata", core_rdata, 32'd0);
        tick();
        #1;
        chk("rr5_addr",  {2'd0, mem_addr}, 32'h9);
        chk("rr5_stall", {31'd0, core_stall}, 32'd1);
        tick();
        #1;
        chk("rr6_rvalid", {31'd0, core_rvalid}, 32'd1);
        tick();
        core_idle();

        // Fixed debug priority with a stream of debug writes
        do_reset();
        core_rd = 1'b1; core_addr = 32'h30; core_size = 3'b010;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h50; dbg_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("pr_dbg_gnt", {31'd0, p_dbg_gnt}, 32'd1);
            chk("pr_stall",   {31'd0, p_core_stall}, 32'd1);
            chk("pr_we",      {31'd0, p_mem_we}, 32'd1);
            tick();
        end
        #1;
        chk("pr_dbg_addr",  {2'd0, p_mem_addr}, 32'h14);
        chk("pr_dbg_wdata", p_mem_wdata, 32'hCAFEF00D);
        chk("pr_dbg_mask",  {28'd0, p_mem_wmask}, 32'hF);
        tick();
        dbg_req = 1'b0; dbg_we = 1'b0;
        #1;
        chk("pr_core_en",    {31'd0, p_mem_en}, 32'd1);
        chk("pr_core_we",    {31'd0, p_mem_we}, 32'd0);
        chk("pr_core_addr",  {2'd0, p_mem_addr}, 32'hC);
        chk("pr_core_stall", {31'd0, p_core_stall}, 32'd1);
        tick();
        mem_rdata = 32'h0BADF00D;
        #1;
        chk("pr_core_rvalid", {31'd0, p_core_rvalid}, 32'd1);
        chk("pr_core_rdata",  p_core_rdata, 32'h0BADF00D);
        tick();
        core_idle();

        // Reset while a core read response is pending
        do_reset();
        core_rd = 1'b1; core_addr = 32'h8; core_size = 3'b010;
        #1;
        chk("rc_stall", {31'd0, core_stall}, 32'd1);
        tick();
        reset = 1'b1;
        core_idle();
        tick();
        reset = 1'b0;
        #1;
        chk("rc_rvalid",    {31'd0, core_rvalid}, 32'd0);
        chk("rc_rdata",     core_rdata, 32'd0);
        chk("rc_en",        {31'd0, mem_en}, 32'd0);
        chk("rc_stall_0",   {31'd0, core_stall}, 32'd0);
        chk("rc_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
